// File: rtl/operand_fetch.sv
// operand_fetch: LC3 operand fetch with 8-entry writeback scoreboard, RAW/WAW stall and writeback forwarding
// Ports: clock/reset (async, active-low); decode side in_valid/in_ready, sr1/sr2/dr, use_sr1/use_sr2/writes_dr, npc_in;
// register file rf_sr1/rf_sr2 -> rf_d1/rf_d2; writeback wb_enable/wb_dr/wb_data; flush;
// execute side out_valid/out_ready, vsr1/vsr2, out_dr/out_writes_dr/out_npc; busy scoreboard.
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     sr1,
    input  logic [AW-1:0]     sr2,
    input  logic [AW-1:0]     dr,
    input  logic              use_sr1,
    input  logic              use_sr2,
    input  logic              writes_dr,
    input  logic [DATA_W-1:0] npc_in,
    output logic [AW-1:0]     rf_sr1,
    output logic [AW-1:0]     rf_sr2,
    input  logic [DATA_W-1:0] rf_d1,
    input  logic [DATA_W-1:0] rf_d2,
    input  logic              wb_enable,
    input  logic [AW-1:0]     wb_dr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] vsr1,
    output logic [DATA_W-1:0] vsr2,
    output logic [AW-1:0]     out_dr,
    output logic              out_writes_dr,
    output logic [DATA_W-1:0] out_npc,
    output logic [NREG-1:0]   busy
);
    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};
    logic [NREG-1:0] clr, busy_next;
    logic            haz1, haz2, hazw, cap;
    assign rf_sr1 = sr1;
    assign rf_sr2 = sr2;
    // One-hot of the register the writeback retires this cycle.
    assign clr  = wb_enable ? ONE << wb_dr : '0;
    assign haz1 = use_sr1 && busy[sr1] && !clr[sr1];
    assign haz2 = use_sr2 && busy[sr2] && !clr[sr2];
    assign hazw = writes_dr && busy[dr] && !clr[dr];
    // Gated by reset so nothing can be accepted while reset is held.
    assign in_ready = reset && (!out_valid || out_ready) && !haz1 && !haz2 && !hazw && !flush;
    assign cap = in_valid && in_ready;
    // Clear, then set (set wins on the same index), then flush release.
    // A flush blocks capture, so the flush release never meets a set.
    always_comb begin
        busy_next = busy & ~clr;
        busy_next = (cap && writes_dr) ? busy_next | (ONE << dr) : busy_next;
        busy_next = (flush && out_valid && out_writes_dr) ? busy_next & ~(ONE << out_dr) : busy_next;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy          <= '0;
            out_valid     <= 1'b0;
            vsr1          <= '0;
            vsr2          <= '0;
            out_dr        <= '0;
            out_writes_dr <= 1'b0;
            out_npc       <= '0;
        end else begin
            busy      <= busy_next;
            out_valid <= cap ? 1'b1 : (flush || out_ready) ? 1'b0 : out_valid;
            if (cap) begin
                vsr1          <= clr[sr1] ? wb_data : rf_d1;
                vsr2          <= clr[sr2] ? wb_data : rf_d2;
                out_dr        <= dr;
                out_writes_dr <= writes_dr;
                out_npc       <= npc_in;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch
module tb_operand_fetch;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  sr1 = '0, sr2 = '0, dr = '0;
    logic        use_sr1 = 1'b0, use_sr2 = 1'b0, writes_dr = 1'b0;
    logic [15:0] npc_in = '0;
    logic [2:0]  rf_sr1, rf_sr2;
    logic [15:0] rf_d1, rf_d2;
    logic        wb_enable = 1'b0;
    logic [2:0]  wb_dr = '0;
    logic [15:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] vsr1, vsr2, out_npc;
    logic [2:0]  out_dr;
    logic        out_writes_dr;
    logic [7:0]  busy;
    logic [15:0] regs [8];
    int checks = 0, failures = 0;

    always #5 clock = ~clock;
    assign rf_d1 = regs[rf_sr1];
    assign rf_d2 = regs[rf_sr2];

    operand_fetch dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sr1(sr1), .sr2(sr2), .dr(dr), .use_sr1(use_sr1), .use_sr2(use_sr2),
        .writes_dr(writes_dr), .npc_in(npc_in), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
        .rf_d1(rf_d1), .rf_d2(rf_d2), .wb_enable(wb_enable), .wb_dr(wb_dr),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .vsr1(vsr1), .vsr2(vsr2), .out_dr(out_dr), .out_writes_dr(out_writes_dr),
        .out_npc(out_npc), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                         input logic u1, input logic u2, input logic w, input logic [15:0] npc);
        in_valid = 1'b1; sr1 = s1; sr2 = s2; dr = d;
        use_sr1 = u1; use_sr2 = u2; writes_dr = w; npc_in = npc;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'h0100 + 16'(i);
        regs[1] = 16'h0005; regs[2] = 16'h000A; regs[3] = 16'h7777; regs[0] = 16'h0042;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_vsr1", vsr1, 0);
        check("rst_out_npc", out_npc, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        // ADD R3 <- R1 + R2
        issue(3'd1, 3'd2, 3'd3, 1, 1, 1, 16'h3001);
        check("rf_sr1_copy", rf_sr1, 1);
        check("rf_sr2_copy", rf_sr2, 2);
        check("add_in_ready", in_ready, 1);
        tick();
        check("add_out_valid", out_valid, 1);
        check("add_vsr1", vsr1, 16'h0005);
        check("add_vsr2", vsr2, 16'h000A);
        check("add_out_dr", out_dr, 3);
        check("add_out_npc", out_npc, 16'h3001);
        check("add_busy", busy, 8'h08);
        // RAW on R3, resolved by forwarding
        issue(3'd3, 3'd0, 3'd5, 1, 0, 0, 16'h3002);
        check("raw_stall0", in_ready, 0);
        tick();
        check("raw_drain", out_valid, 0);
        check("raw_stall1", in_ready, 0);
        check("raw_busy_held", busy, 8'h08);
        wb_enable = 1'b1; wb_dr = 3'd3; wb_data = 16'h1234;
        #1;
        check("raw_wb_ready", in_ready, 1);
        tick();
        wb_enable = 1'b0;
        check("raw_fwd_vsr1", vsr1, 16'h1234);
        check("raw_busy_clr", busy, 8'h00);
        check("raw_out_valid", out_valid, 1);
        // WAW on R4
        issue(3'd0, 3'd0, 3'd4, 0, 0, 1, 16'h3003);
        check("waw_first_ready", in_ready, 1);
        tick();
        check("waw_busy_set", busy, 8'h10);
        issue(3'd0, 3'd0, 3'd4, 0, 0, 1, 16'h3004);
        check("waw_stall0", in_ready, 0);
        tick();
        check("waw_stall1", in_ready, 0);
        check("waw_busy_hold", busy, 8'h10);
        wb_enable = 1'b1; wb_dr = 3'd4; wb_data = 16'h5555;
        #1;
        check("waw_wb_ready", in_ready, 1);
        tick();
        wb_enable = 1'b0;
        check("waw_set_wins", busy, 8'h10);
        check("waw_out_npc", out_npc, 16'h3004);
        check("waw_out_dr", out_dr, 4);
        // Backpressure for 3 cycles
        out_ready = 1'b0;
        issue(3'd1, 3'd0, 3'd0, 1, 0, 0, 16'h3005);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 0);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_npc", out_npc, 16'h3004);
            check("bp_out_dr", out_dr, 4);
            check("bp_out_wdr", out_writes_dr, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_nobubble_valid", out_valid, 1);
        check("bp_nobubble_npc", out_npc, 16'h3005);
        check("bp_nobubble_vsr1", vsr1, 16'h0005);
        // Flush a held packet writing R6
        wb_enable = 1'b1; wb_dr = 3'd4;
        issue(3'd0, 3'd0, 3'd6, 0, 0, 1, 16'h3006);
        tick();
        wb_enable = 1'b0;
        check("fl_busy_pre", busy, 8'h40);
        check("fl_out_dr", out_dr, 6);
        out_ready = 1'b0; flush = 1'b1;
        issue(3'd0, 3'd0, 3'd7, 0, 0, 1, 16'h3007);
        check("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_busy", busy, 8'h00);
        // Fill scoreboard, stall, then async reset mid-cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(3'd0, 3'd0, 3'(i), 0, 0, 1, 16'h3100 + 16'(i));
            tick();
        end
        check("fill_busy", busy, 8'hFF);
        out_ready = 1'b0;
        issue(3'd0, 3'd0, 3'd0, 1, 0, 0, 16'h3200);
        check("fill_stall0", in_ready, 0);
        tick();
        check("fill_stall_valid", out_valid, 1);
        check("fill_stall_busy", busy, 8'hFF);
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 8'h00);
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        #1;
        reset = 1'b1; out_ready = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1);
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_vsr1", vsr1, 16'h0042);
        check("post_rst_npc", out_npc, 16'h3200);
        in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
